// File: rtl/type_package.sv
// type_package: shared types for pio_master.
//   pio_cmd_type : registered host command (rw, addr, wdata)
//   pio_state_e  : access FSM states
`include "defines.vh"
package type_package;

    localparam int unsigned PIO_NBITS = `PIO_NBITS;
    localparam int unsigned TIMER_W   = 16;

    typedef struct packed {
        logic                 rw;
        logic [PIO_NBITS-1:0] addr;
        logic [PIO_NBITS-1:0] wdata;
    } pio_cmd_type;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } pio_state_e;

endpackage

// File: rtl/defines.vh
// Global PIO bus width macros shared by the package and the top.
`ifndef PIO_DEFINES_VH
`define PIO_DEFINES_VH
`define PIO_NBITS 32
`define PIO_RANGE `PIO_NBITS-1:0
`endif

// File: rtl/pio_master_timer.sv
// pio_master_timer: WAIT-state cycle budget counter.
//   clk, rstn : clock, async active-low reset
//   clear     : zero the count (entering WAIT)
//   enable    : count this cycle (in WAIT)
//   expire_c  : combinational, high during the last budgeted WAIT cycle
module pio_master_timer
    import type_package::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Count starts at 0 in the first WAIT cycle, so cycle N-1 is the Nth.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    assign expire_c = enable && (count_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pio_master.sv
// pio_master: single-outstanding host-to-PIO bus access master.
//   cmd_*  : host command handshake (valid/ready, rw, addr, wdata)
//   rsp_*  : host completion handshake (valid/ready, rdata, err)
//   pio_*  : PIO bus start strobe, direction, addr/wdata beats, ack/rvalid/rdata
// Optional feature macro PIO_MASTER_TIMEOUT_EN adds a WAIT timeout
// (TIMEOUT_CYCLES, legal 2..65535) reporting rsp_err=1, rdata=all-ones.
`include "defines.vh"
module pio_master
    import type_package::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [`PIO_NBITS-1:0] cmd_addr,
    input  logic [`PIO_NBITS-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [`PIO_NBITS-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  pio_start,
    output logic                  pio_rw,
    output logic [`PIO_RANGE]     pio_addr_wdata,
    input  logic                  pio_ack,
    input  logic                  pio_rvalid,
    input  logic [`PIO_RANGE]     pio_rdata
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("pio_master: TIMEOUT_CYCLES out of range 2..65535");
    end

    pio_state_e             state_q, state_d;
    pio_cmd_type            cmd_q, cmd_d, cur_cmd;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [PIO_NBITS-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                   pio_start_q, pio_start_d;
    logic                   pio_rw_q, pio_rw_d;
    logic [PIO_NBITS-1:0]   pio_aw_q, pio_aw_d;
    logic                   done_c;
    logic                   expire_c;

`ifdef PIO_MASTER_TIMEOUT_EN
    logic timer_clear_c;
    logic timer_en_c;

    assign timer_clear_c = (state_d == WAIT) && (state_q != WAIT);
    assign timer_en_c    = (state_q == WAIT);

    pio_master_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (timer_clear_c),
        .enable   (timer_en_c),
        .expire_c (expire_c)
    );
`else
    assign expire_c = 1'b0;
`endif

    // Next state, command capture and response payload.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cur_cmd     = cmd_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        done_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_d   = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
                    cur_cmd = cmd_d;
                    state_d = ADDR;
                end
            end
            ADDR: state_d = cmd_q.rw ? WAIT : DATA;
            DATA: state_d = WAIT;
            WAIT: begin
                // Only the strobe matching the direction completes; completion beats expiry.
                done_c = cmd_q.rw ? pio_rvalid : pio_ack;
                if (done_c) begin
                    state_d     = RESP;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = cmd_q.rw ? pio_rdata : '0;
                end else if (expire_c) begin
                    state_d     = RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs follow the state being entered.
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        pio_start_d = (state_d == ADDR);
        pio_rw_d    = ((state_d == ADDR) || (state_d == DATA)) ? cur_cmd.rw : 1'b0;
        pio_aw_d    = '0;
        if (state_d == ADDR) begin
            pio_aw_d = cur_cmd.addr;
        end else if (state_d == DATA) begin
            pio_aw_d = cur_cmd.wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            pio_start_q <= 1'b0;
            pio_rw_q    <= 1'b0;
            pio_aw_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            pio_start_q <= pio_start_d;
            pio_rw_q    <= pio_rw_d;
            pio_aw_q    <= pio_aw_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign pio_start      = pio_start_q;
    assign pio_rw         = pio_rw_q;
    assign pio_addr_wdata = pio_aw_q;

endmodule

// File: tb/tb_pio_master.sv
// tb_pio_master: directed, table-driven bench for pio_master.
module tb_pio_master;

    typedef struct {
        string       name;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;      // WAIT cycles before the target responds
        logic [31:0] rdata_in;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;    // acceptance edge to rsp_valid, in cycles
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        pio_start, pio_rw;
    logic [31:0] pio_addr_wdata;
    logic        pio_ack, pio_rvalid;
    logic [31:0] pio_rdata;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    pio_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_rw         (cmd_rw),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .pio_start      (pio_start),
        .pio_rw         (pio_rw),
        .pio_addr_wdata (pio_addr_wdata),
        .pio_ack        (pio_ack),
        .pio_rvalid     (pio_rvalid),
        .pio_rdata      (pio_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pio_start === 1'b1) start_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete access with immediate rsp_ready; wrong-direction strobes pulse while waiting.
    task automatic run_txn(input vec_t v);
        int lat;
        int s0;
        cmd_valid = 1'b1; cmd_rw = v.rw; cmd_addr = v.addr; cmd_wdata = v.wdata;
        check({v.name, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        s0 = start_cnt;
        tick();
        lat = 1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        check({v.name, ".start"}, 32'(pio_start), 32'd1);
        check({v.name, ".rw"}, 32'(pio_rw), 32'(v.rw));
        check({v.name, ".addr_beat"}, pio_addr_wdata, v.addr);
        check({v.name, ".busy"}, 32'(cmd_ready), 32'd0);
        if (!v.rw) begin
            tick(); lat++;
            check({v.name, ".data_start"}, 32'(pio_start), 32'd0);
            check({v.name, ".data_beat"}, pio_addr_wdata, v.wdata);
        end
        tick(); lat++;
        check({v.name, ".wait_start"}, 32'(pio_start), 32'd0);
        check({v.name, ".wait_bus"}, pio_addr_wdata, 32'd0);
        for (int k = 0; k < v.delay; k++) begin
            if (v.rw) pio_ack = 1'b1;
            else begin pio_rvalid = 1'b1; pio_rdata = 32'hDEAD_BEEF; end
            tick(); lat++;
            pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;
            check({v.name, ".no_rsp_yet"}, 32'(rsp_valid), 32'd0);
        end
        if (v.rw) begin pio_rvalid = 1'b1; pio_rdata = v.rdata_in; end
        else pio_ack = 1'b1;
        tick(); lat++;
        pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;
        check({v.name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({v.name, ".latency"}, 32'(lat), 32'(v.exp_lat));
        check({v.name, ".rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        check({v.name, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({v.name, ".one_start"}, 32'(start_cnt - s0), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({v.name, ".rsp_done"}, 32'(rsp_valid), 32'd0);
        check({v.name, ".ready_again"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[$];
        int   s0;
        int   rsps;

        vecs.push_back('{"wr40",   1'b0, 32'h0000_0040, 32'hA5A5_0001, 2, 32'h0,         32'h0,         1'b0, 6});
        vecs.push_back('{"rd44",   1'b1, 32'h0000_0044, 32'h0,         0, 32'h1234_5678, 32'h1234_5678, 1'b0, 3});
        vecs.push_back('{"wrfast", 1'b0, 32'hFFFF_FFFC, 32'h0,         0, 32'h0,         32'h0,         1'b0, 4});
        vecs.push_back('{"rd5",    1'b1, 32'h0000_1000, 32'h0,         5, 32'h8000_0001, 32'h8000_0001, 1'b0, 8});
        vecs.push_back('{"rdedge", 1'b1, 32'h0000_2000, 32'h0,         7, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 10});
        vecs.push_back('{"wredge", 1'b0, 32'h0000_3000, 32'h5A5A_5A5A, 7, 32'h0,         32'h0,         1'b0, 11});
`ifndef PIO_MASTER_TIMEOUT_EN
        vecs.push_back('{"rdslow", 1'b1, 32'h0000_4000, 32'h0,        30, 32'h0000_A0A0, 32'h0000_A0A0, 1'b0, 33});
`endif

        rstn = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;

        // Reset state
        tick(); tick();
        check("rst.cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        check("rst.pio_start", 32'(pio_start), 32'd0);
        check("rst.pio_rw", 32'(pio_rw), 32'd0);
        check("rst.pio_bus", pio_addr_wdata, 32'd0);
        rstn = 1'b1;
        tick();
        check("post_rst.cmd_ready", 32'(cmd_ready), 32'd1);

        // Spurious target strobes in IDLE are dropped
        pio_ack = 1'b1; pio_rvalid = 1'b1; pio_rdata = 32'h1357_9BDF;
        tick();
        pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;
        check("spur.cmd_ready", 32'(cmd_ready), 32'd1);
        check("spur.rsp_valid", 32'(rsp_valid), 32'd0);

        foreach (vecs[i]) run_txn(vecs[i]);

`ifdef PIO_MASTER_TIMEOUT_EN
        // Read with no response abandons after 8 WAIT cycles
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 32'h0000_0048;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) begin
            tick();
            check("to.waiting", 32'(rsp_valid), 32'd0);
        end
        tick();
        check("to.rsp_valid", 32'(rsp_valid), 32'd1);
        check("to.rsp_err", 32'(rsp_err), 32'd1);
        check("to.rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
        tick(); tick();
        pio_rvalid = 1'b1; pio_rdata = 32'h0000_1111;
        tick();
        pio_rvalid = 1'b0; pio_rdata = '0;
        check("to.late_err", 32'(rsp_err), 32'd1);
        check("to.late_rdata", rsp_rdata, 32'hFFFF_FFFF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("to.done", 32'(rsp_valid), 32'd0);
        check("to.err_clr", 32'(rsp_err), 32'd0);
        check("to.ready", 32'(cmd_ready), 32'd1);
`endif

        // Response stall: held stable, next command waits for the handshake
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 32'h0000_0050;
        tick();
        cmd_valid = 1'b0;
        tick();
        pio_rvalid = 1'b1; pio_rdata = 32'hCAFE_0001;
        tick();
        pio_rvalid = 1'b0; pio_rdata = '0;
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h0000_0060; cmd_wdata = 32'h0000_0077;
        for (int k = 0; k < 5; k++) begin
            check("stall.rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall.rdata", rsp_rdata, 32'hCAFE_0001);
            check("stall.cmd_ready", 32'(cmd_ready), 32'd0);
            if (k == 2) pio_ack = 1'b1;
            tick();
            pio_ack = 1'b0;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("stall.idle_ready", 32'(cmd_ready), 32'd1);
        check("stall.no_early_start", 32'(pio_start), 32'd0);
        tick();
        cmd_valid = 1'b0;
        check("stall.next_start", 32'(pio_start), 32'd1);
        check("stall.next_addr", pio_addr_wdata, 32'h0000_0060);
        tick();
        check("stall.next_data", pio_addr_wdata, 32'h0000_0077);
        tick();
        pio_ack = 1'b1;
        tick();
        pio_ack = 1'b0;
        check("stall.next_rsp", 32'(rsp_valid), 32'd1);
        check("stall.next_rdata", rsp_rdata, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset during WAIT of a write abandons it
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h0000_0070; cmd_wdata = 32'h0000_0099;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        rstn = 1'b0;
        #1;
        check("mid_rst.cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst.pio_start", 32'(pio_start), 32'd0);
        check("mid_rst.pio_bus", pio_addr_wdata, 32'd0);
        check("mid_rst.rsp_valid", 32'(rsp_valid), 32'd0);
        pio_ack = 1'b1;
        tick();
        pio_ack = 1'b0;
        rstn = 1'b1;
        tick();
        check("mid_rst.ready", 32'(cmd_ready), 32'd1);
        check("mid_rst.no_rsp", 32'(rsp_valid), 32'd0);
        run_txn('{"rd_after_rst", 1'b1, 32'h0000_0074, 32'h0, 1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 4});

        // Back-to-back reads with cmd_valid held: 4-cycle turnaround each
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 32'h0000_0080;
        rsp_ready = 1'b1; pio_rvalid = 1'b1; pio_rdata = 32'h0BAD_F00D;
        s0 = start_cnt;
        rsps = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                rsps++;
                check("b2b.rdata", rsp_rdata, 32'h0BAD_F00D);
            end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;
        tick();
        check("b2b.starts", 32'(start_cnt - s0), 32'd3);
        check("b2b.rsps", 32'(rsps), 32'd3);
        check("b2b.idle", 32'(cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_master.md
PIO_MASTER -- requirements
Module: pio_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, is the WAIT-state cycle budget before an access is abandoned; legal range 2..65535.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 `RESET_SIG (rstn)  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  host command request.
REQ-005 cmd_ready  output  1  block accepts a command this cycle.
REQ-006 cmd_rw  input  1  1=read, 0=write.
REQ-007 cmd_addr, cmd_wdata  input  `PIO_NBITS each  access address and write data.
REQ-008 rsp_valid  output  1  completion available.
REQ-009 rsp_ready  input  1  host consumes completion.
REQ-010 rsp_rdata  output  `PIO_NBITS  read data; 0 for writes.
REQ-011 rsp_err  output  1  access timed out.
REQ-012 pio_start, pio_rw  output  1 each  PIO bus start strobe and direction.
REQ-013 pio_addr_wdata  output  `PIO_RANGE  address beat, then write-data beat.
REQ-014 pio_ack, pio_rvalid  input  1 each  write completion / read data valid from the target.
REQ-015 pio_rdata  input  `PIO_RANGE  read data, qualified by pio_rvalid.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR, DATA, WAIT, RESP; one access is outstanding at a time.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid&cmd_ready and rw/addr/wdata are registered.
REQ-018 IDLE->ADDR on acceptance; in ADDR, pio_start=1, pio_rw=cmd_rw, pio_addr_wdata=addr for exactly one cycle.
REQ-019 ADDR->DATA for writes (pio_addr_wdata=wdata, pio_start=0, one cycle) then DATA->WAIT; reads go ADDR->WAIT directly.
REQ-020 Outside ADDR/DATA, pio_start=0 and pio_addr_wdata=0.
REQ-021 In WAIT, a write completes on pio_ack and a read completes on pio_rvalid (pio_rdata captured the same cycle); pio_ack during a read and pio_rvalid during a write are ignored.
REQ-022 Completion moves WAIT->RESP the next cycle with rsp_err=0; rsp_valid=1 in RESP, held stable until rsp_ready, then RESP->IDLE.
REQ-023 pio_ack/pio_rvalid arriving outside WAIT (late or spurious) are discarded with no state change.
REQ-024 Minimum latency from acceptance to rsp_valid: 3 cycles for a read, 4 for a write, given a same-cycle response in WAIT.
REQ-025 cmd_valid while not in IDLE is not accepted; the host holds it.

Reset
REQ-026 On rstn low, FSM=IDLE, timeout counter=0, and cmd_ready=0 while asserted; rsp_valid, rsp_err, pio_start, pio_rw=0; pio_addr_wdata, rsp_rdata=0.
REQ-027 Reset mid-access abandons it with no response; cmd_ready=1 the first cycle after deassertion.

Configuration
REQ-028 With PIO_MASTER_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entering WAIT and increment each WAIT cycle; on reaching TIMEOUT_CYCLES without completion, WAIT->RESP with rsp_err=1 and rsp_rdata=all-ones.
REQ-029 Without PIO_MASTER_TIMEOUT_EN, no counter is built, WAIT waits indefinitely, and rsp_err is tied 0.
REQ-030 If completion and timeout expiry coincide, completion wins (rsp_err=0).

Structure
REQ-031 pio_cmd_type (rw, addr, wdata) and the FSM state enum SHALL live in type_package; `PIO_NBITS/`PIO_RANGE come from defines.vh.
REQ-032 One sub-module, pio_master_timer (clear/enable/expire, parameter TIMEOUT_CYCLES), is instantiated only under PIO_MASTER_TIMEOUT_EN.

Verification
REQ-033 Write addr=0x0040, wdata=0xA5A5_0001, pio_ack 2 cycles into WAIT -> start beat addr, then data beat; rsp_valid with rsp_err=0, rdata=0.
REQ-034 Read addr=0x0044, pio_rvalid with pio_rdata=0x1234_5678 -> rsp_rdata=0x1234_5678, single pio_start, no data beat.
REQ-035 TIMEOUT_EN, TIMEOUT_CYCLES=8, read with no response -> rsp_err=1, rdata=0xFFFF_FFFF after 8 WAIT cycles; pio_rvalid 2 cycles later is ignored.
REQ-036 rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable; cmd_ready=0 throughout; new command accepted the cycle after the handshake.
REQ-037 rstn asserted in WAIT of a write -> outputs at reset values, no rsp_valid; next read completes normally.
REQ-038 Back-to-back commands with cmd_valid held high -> exactly one pio_start per command, no overlap.
